k_dp_2deep_fifo_ctrl: RTL

Pointer/flag controller that owns both ends of the team's 2-deep dual-port RAM.
- Upstream side: converts a producer's valid/ready push handshake into the RAM write strobe and write address.
- Downstream side: converts a consumer's valid/ready pop handshake into the RAM read address.
- Data does not pass through this block: the producer drives RAM d directly and the consumer samples RAM q, which is combinational from raddr.
- Together with the RAM it forms the FIFO used on the FIFO datapaths.

---
 rtl/k_dp_2deep_fifo_ctrl.sv | 63 ++++++
 1 files changed

// File: rtl/k_dp_2deep_fifo_ctrl.sv
// Pointer/flag controller for the 2-deep dual-port RAM FIFO.
// Data stays in the RAM; this block only produces write strobe, addresses and flags.
module k_dp_2deep_fifo_ctrl #(
   parameter int ADDR_W = 1,
   parameter int CNT_W  = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [ADDR_W-1:0] ram_raddr,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   localparam int                DEPTH   = 1 << ADDR_W;
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;
   logic              push;
   logic              pop;

   // Valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
   // Readies and valids depend only on registered state, rst and flush, never on the
   // opposite side's handshake input.
   assign full      = (count == DEPTH_C);
   assign empty     = (count == '0);
   assign in_ready  = !full  && !rst && !flush;
   assign out_valid = !empty && !rst && !flush;
   assign push      = in_valid  && in_ready;
   assign pop       = out_valid && out_ready;

   assign ram_wen   = push;
   assign ram_waddr = wptr;
   assign ram_raddr = rptr;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_ONE;
         if (pop)  rptr <= rptr + PTR_ONE;
         // Simultaneous push and pop leaves occupancy unchanged.
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule
